fib_sequencer: RTL
==================

FIB_SEQUENCER -- requirements
Module: fib_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, sets the immediate width.
REQ-002 Parameter NUM_REGS, default 16, sets the register count; it also sets the width of enable; legal range 4..31.
REQ-003 Parameter SEL_W, default 5, sets the mux select width; code 0 selects none, code i+1 selects Ri.
REQ-004 Parameter OP_W, default 8, sets the opcode width; parameter OP_ADD, default 8'b00000101, is the ALU add opcode.
REQ-005 The block SHALL use one clock, clk, and one reset, reset; reset is asynchronous and active-low.
REQ-006 Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous active-low reset.
- start, input, 1: request a run; sampled in IDLE only.
- num_terms, input, clog2(NUM_REGS): index of the last register to write.
- hold, input, 1: pause the run.
- alu_carry, input, 1: ALU carry-out of the current add.
- immediate, output, DATA_W: immediate operand.
- imm_control, output, 1: selects immediate as the right ALU operand.
- enable, output, NUM_REGS: one-hot register write enable.
- control1, output, SEL_W: left mux select.
- control2, output, SEL_W: right mux select.
- opcode, output, OP_W: ALU operation.
- buff_en, output, 1: drives the ALU result onto the bus.
- busy, output, 1: a run is in progress.
- done, output, 1: one-cycle end-of-run pulse.
- overflow, output, 1: sticky flag, run aborted on carry.

Function
REQ-007 States SHALL be IDLE, SEED1, SEED2, ITER, DONE; all state flops SHALL update on the rising edge of clk.
REQ-008 IDLE SHALL move to SEED1 when start=1; start SHALL be ignored in every other state.
REQ-009 On start, the block SHALL latch the target N = clamp(num_terms, 2, NUM_REGS-1) and SHALL clear overflow.
REQ-010 SEED1 SHALL output: enable bit 1, control1=1 (R0), control2=0, imm_control=1, immediate=1, opcode=OP_ADD, buff_en=1.
REQ-011 SEED1 SHALL then go to SEED2.
REQ-012 SEED2 SHALL output the same as SEED1 except enable bit 2.
REQ-013 SEED2 SHALL go to DONE if N=2, otherwise to ITER with k=3.
REQ-014 ITER SHALL output, for term k: enable bit k, control1=k-1 (R(k-2)), control2=k (R(k-1)), imm_control=0, immediate=0, opcode=OP_ADD, buff_en=1.
REQ-015 ITER SHALL increment k each cycle and SHALL go to DONE after writing k=N.
REQ-016 Register Rk SHALL be written in the k-th cycle after the start-sampling edge; done SHALL assert in cycle N+1 for exactly one cycle, after which the state returns to IDLE.
REQ-017 In IDLE and DONE, all datapath outputs (immediate, imm_control, enable, control1, control2, opcode, buff_en) SHALL be 0.
REQ-018 busy SHALL be 1 in SEED1, SEED2 and ITER.
REQ-019 While hold=1 in a busy state, state and k SHALL freeze and enable and buff_en SHALL be 0; the other outputs SHALL keep their values.
REQ-020 When hold is released, the run SHALL resume with the same term, so no term is skipped or written twice.
REQ-021 If alu_carry=1 in an ITER cycle with hold=0, that term's write SHALL still occur; overflow SHALL then set and the next state SHALL be DONE, with no further writes.
REQ-022 alu_carry SHALL be ignored outside ITER.
REQ-023 overflow SHALL hold its value until the next accepted start or reset.
REQ-024 If hold and the final term coincide, DONE SHALL be deferred until hold is released.

Reset
REQ-025 reset=0 SHALL asynchronously force IDLE, k=0, N=2, overflow=0, done=0 and all datapath outputs to 0, including mid-run.
REQ-026 After reset release, the block SHALL stay in IDLE until a start is sampled.

Structure
REQ-027 OP_ADD, the state encoding, and the select-code rule (register index plus 1, 0 means none) SHALL live in a shared package cpu_ctrl_pkg.
REQ-028 No sub-module is required; the output decode SHALL be a single combinational block keyed on state and k.

Verification
REQ-029 Basic run: num_terms=5 plus start.
- Writes R1..R5 in cycles 1..5.
- Datapath model gives 1, 1, 2, 3, 5.
- done pulses in cycle 6.
REQ-030 Long run: num_terms=12.
- R12=144 (0x0090).
- done pulses in cycle 13; busy is high in cycles 1..12.
REQ-031 Clamping:
- num_terms=0 writes R1 and R2 only; done in cycle 3.
- num_terms=15 with NUM_REGS=16 writes R15=610.
REQ-032 Overflow: alu_carry forced to 1 in the R6 cycle.
- R6 is written, overflow=1, done in cycle 7, and R7 is never enabled.
- The next start clears overflow.
REQ-033 Hold: hold=1 for 3 cycles during R4.
- enable=0 during the hold.
- R4 is written once after release; done is delayed by 3 cycles.
REQ-034 Reset and start rules:
- reset=0 asserted mid-run in the R3 cycle forces all outputs to 0 immediately.
- start pulsed while busy is ignored.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared control constants: ALU opcode, sequencer state codes, mux select rule
package cpu_ctrl_pkg;

  localparam logic [7:0] OP_ADD = 8'b00000101;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEED1 = 3'd1;
  localparam logic [2:0] S_SEED2 = 3'd2;
  localparam logic [2:0] S_ITER  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Mux select code for register Ri; code 0 means no register.
  function automatic int sel_code(input int idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/fib_sequencer.sv
// rtl/fib_sequencer.sv - control FSM driving a register-file/ALU datapath to fill R1..RN with Fibonacci terms
module fib_sequencer #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 5,
  parameter int OP_W     = 8,
  parameter logic [OP_W-1:0] OP_ADD = OP_W'(cpu_ctrl_pkg::OP_ADD)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [$clog2(NUM_REGS)-1:0] num_terms,
  input  logic                        hold,
  input  logic                        alu_carry,
  output logic [DATA_W-1:0]           immediate,
  output logic                        imm_control,
  output logic [NUM_REGS-1:0]         enable,
  output logic [SEL_W-1:0]            control1,
  output logic [SEL_W-1:0]            control2,
  output logic [OP_W-1:0]             opcode,
  output logic                        buff_en,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [2:0]       state;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] n;
  logic [IDX_W-1:0] n_clamp;

  // num_terms can exceed the register count when NUM_REGS is not a power of two
  always_comb begin
    n_clamp = num_terms;
    if (num_terms < IDX_W'(2))
      n_clamp = IDX_W'(2);
    else if (int'(num_terms) > NUM_REGS - 1)
      n_clamp = IDX_W'(NUM_REGS - 1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= cpu_ctrl_pkg::S_IDLE;
      k        <= '0;
      n        <= IDX_W'(2);
      overflow <= 1'b0;
    end else begin
      case (state)
        cpu_ctrl_pkg::S_IDLE: begin
          if (start) begin
            state    <= cpu_ctrl_pkg::S_SEED1;
            n        <= n_clamp;
            overflow <= 1'b0;
          end
        end
        cpu_ctrl_pkg::S_SEED1: begin
          if (!hold) state <= cpu_ctrl_pkg::S_SEED2;
        end
        cpu_ctrl_pkg::S_SEED2: begin
          if (!hold) begin
            if (n == IDX_W'(2)) begin
              state <= cpu_ctrl_pkg::S_DONE;
            end else begin
              state <= cpu_ctrl_pkg::S_ITER;
              k     <= IDX_W'(3);
            end
          end
        end
        cpu_ctrl_pkg::S_ITER: begin
          // the carrying term is still written this cycle; the run stops after it
          if (!hold) begin
            if (alu_carry) begin
              overflow <= 1'b1;
              state    <= cpu_ctrl_pkg::S_DONE;
            end else if (k == n) begin
              state <= cpu_ctrl_pkg::S_DONE;
            end else begin
              k <= k + IDX_W'(1);
            end
          end
        end
        default: state <= cpu_ctrl_pkg::S_IDLE;
      endcase
    end
  end

  always_comb begin
    immediate   = '0;
    imm_control = 1'b0;
    enable      = '0;
    control1    = '0;
    control2    = '0;
    opcode      = '0;
    buff_en     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      cpu_ctrl_pkg::S_SEED1, cpu_ctrl_pkg::S_SEED2: begin
        busy        = 1'b1;
        imm_control = 1'b1;
        immediate   = DATA_W'(1);
        control1    = SEL_W'(cpu_ctrl_pkg::sel_code(0));
        opcode      = OP_ADD;
        buff_en     = !hold;
        if (!hold)
          enable = (state == cpu_ctrl_pkg::S_SEED1) ? NUM_REGS'(2) : NUM_REGS'(4);
      end
      cpu_ctrl_pkg::S_ITER: begin
        busy     = 1'b1;
        control1 = SEL_W'(cpu_ctrl_pkg::sel_code(int'(k) - 2));
        control2 = SEL_W'(cpu_ctrl_pkg::sel_code(int'(k) - 1));
        opcode   = OP_ADD;
        buff_en  = !hold;
        if (!hold)
          enable = NUM_REGS'(1) << k;
      end
      cpu_ctrl_pkg::S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
